// File: rtl/tflipflop_bank_pkg.sv
// Shared definitions for the toggle flip-flop bank:
// channel mode codes and burst sequencer states.
package tflipflop_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_DIV    = 2'b01;
    localparam logic [1:0] MODE_FREE   = 2'b10;
    localparam logic [1:0] MODE_BURST  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } burst_st_e;

endpackage

// File: rtl/tflipflop_bank_if.sv
// Packed per-channel control and status buses of the bank.
// master drives controls, slave is the bank itself.
interface tflipflop_bank_if #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 16,
    parameter int CNT_W    = 16
);

    logic [CHANNELS-1:0]       t;
    logic [2*CHANNELS-1:0]     mode;
    logic [DIV_W*CHANNELS-1:0] div;
    logic [CNT_W*CHANNELS-1:0] burst;
    logic [CHANNELS-1:0]       start;
    logic [CHANNELS-1:0]       clear;
    logic [CHANNELS-1:0]       q;
    logic [CHANNELS-1:0]       qbar;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       done;

    modport master (
        output t, mode, div, burst, start, clear,
        input  q, qbar, busy, done
    );

    modport slave (
        input  t, mode, div, burst, start, clear,
        output q, qbar, busy, done
    );

endinterface

// File: rtl/tflipflop_chan.sv
// One toggle channel: direct, divided, free-running
// and counted-burst toggling of a single q register.
module tflipflop_chan
    import tflipflop_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] burst,
    input  logic             start,
    input  logic             clear,
    output logic             q,
    output logic             qbar,
    output logic             busy,
    output logic             done
);

    burst_st_e        state;
    burst_st_e        state_d;
    logic [1:0]       mode_q;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] presc_d;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_d;
    logic             q_d;
    logic             busy_d;
    logic             done_d;
    logic             hit;

    assign hit  = (presc == div);
    assign qbar = ~q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode_q    <= MODE_DIRECT;
            presc     <= '0;
            remaining <= '0;
            q         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            mode_q    <= mode;
            presc     <= presc_d;
            remaining <= remaining_d;
            q         <= q_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // done is only ever raised on the transition into DONE
    always_comb begin
        state_d     = state;
        presc_d     = presc;
        remaining_d = remaining;
        q_d         = q;
        busy_d      = busy;
        done_d      = 1'b0;
        if (clear) begin
            state_d     = IDLE;
            presc_d     = '0;
            remaining_d = '0;
            q_d         = 1'b0;
            busy_d      = 1'b0;
        end else if (mode != mode_q) begin
            state_d     = IDLE;
            presc_d     = '0;
            remaining_d = '0;
            busy_d      = 1'b0;
        end else begin
            unique case (mode)
                MODE_DIRECT: begin
                    if (t) q_d = ~q;
                end
                MODE_DIV, MODE_FREE: begin
                    if (t) begin
                        if (hit) begin
                            q_d     = ~q;
                            presc_d = '0;
                        end else begin
                            presc_d = presc + 1'b1;
                        end
                    end
                end
                MODE_BURST: begin
                    unique case (state)
                        IDLE: begin
                            if (start) begin
                                if (burst != '0) begin
                                    state_d     = RUN;
                                    busy_d      = 1'b1;
                                    presc_d     = '0;
                                    remaining_d = burst;
                                end else begin
                                    state_d = DONE;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                        RUN: begin
                            if (hit) begin
                                q_d         = ~q;
                                presc_d     = '0;
                                remaining_d = remaining - 1'b1;
                                if (remaining == CNT_W'(1)) begin
                                    state_d = DONE;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                end
                            end else begin
                                presc_d = presc + 1'b1;
                            end
                        end
                        DONE: begin
                            state_d = IDLE;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/tflipflop_bank.sv
// Bank of independent toggle channels sharing one clock
// and reset, sliced out of the packed interface buses.
module tflipflop_bank
    import tflipflop_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    tflipflop_bank_if.slave  bus
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        tflipflop_chan #(
            .DIV_W (DIV_W),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .t     (bus.t[i]),
            .mode  (bus.mode[2*i +: 2]),
            .div   (bus.div[DIV_W*i +: DIV_W]),
            .burst (bus.burst[CNT_W*i +: CNT_W]),
            .start (bus.start[i]),
            .clear (bus.clear[i]),
            .q     (bus.q[i]),
            .qbar  (bus.qbar[i]),
            .busy  (bus.busy[i]),
            .done  (bus.done[i])
        );
    end

endmodule

// File: tb/tb_tflipflop_bank.sv
// Scoreboard bench for the 4-channel toggle bank.
// Observed word is {q, qbar, busy, done}, 4 bits each.
module tb_tflipflop_bank;

    localparam int CH = 4;
    localparam int DW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;

    tflipflop_bank_if #(
        .CHANNELS (CH),
        .DIV_W    (DW),
        .CNT_W    (CW)
    ) bif ();

    tflipflop_bank #(
        .CHANNELS (CH),
        .DIV_W    (DW),
        .CNT_W    (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;

    logic [15:0] obs;
    assign obs = {bif.q, bif.qbar, bif.busy, bif.done};

    function automatic logic [15:0] pk(logic [3:0] q,
                                       logic [3:0] b,
                                       logic [3:0] d);
        return {q, ~q, b, d};
    endfunction

    task automatic expect_v(logic [15:0] v, string nm);
        exp_t x;
        x.v  = v;
        x.nm = nm;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.t     = '0;
        bif.mode  = '0;
        bif.div   = '0;
        bif.burst = '0;
        bif.start = '0;
        bif.clear = '0;
    endtask

    task automatic set_ch(int i, logic [1:0] m,
                          logic [15:0] d, logic [15:0] b);
        bif.mode[2*i +: 2]   = m;
        bif.div[16*i +: 16]  = d;
        bif.burst[16*i +: 16] = b;
    endtask

    task automatic clear_all();
        bif.clear = '1;
        tick();
        bif.clear = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        bif.t = '1;
        reset = 1'b0;
        #1;
        expect_v(pk(4'h0, 4'h0, 4'h0), "reset async");
        e = sb.pop_front();
        checks++;
        if (obs !== e.v)
            $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
        else
            passes++;
        expect_v(pk(4'h0, 4'h0, 4'h0), "reset held t=1");
        tick();
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e.v)
            $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
        else
            passes++;
        idle();
        reset = 1'b1;
    endtask

    task automatic test_direct();
        exp_t e;
        logic qe;
        qe = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bif.t = (c < 3) ? 4'b0001 : 4'b0000;
            if (c < 3) qe = ~qe;
            expect_v(pk({3'b0, qe}, 4'h0, 4'h0),
                     $sformatf("direct c%0d", c));
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e.v)
                $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
            else
                passes++;
        end
        idle();
    endtask

    task automatic test_divided();
        exp_t e;
        logic qe;
        int   n;
        idle();
        set_ch(1, 2'b01, 16'd2, 16'd0);
        clear_all();
        qe = 1'b0;
        n  = 0;
        for (int c = 0; c < 19; c++) begin
            bif.t = (c != 13) ? 4'b0010 : 4'b0000;
            if (c != 13) begin
                n++;
                if (n % 3 == 0) qe = ~qe;
            end
            expect_v(pk({2'b0, qe, 1'b0}, 4'h0, 4'h0),
                     $sformatf("divided c%0d", c));
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e.v)
                $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
            else
                passes++;
        end
        idle();
    endtask

    task automatic test_free();
        exp_t e;
        logic qe;
        int   n;
        idle();
        set_ch(2, 2'b10, 16'd3, 16'd0);
        clear_all();
        n = 0;
        for (int c = 0; c < 27; c++) begin
            if (c >= 18 && c < 21) begin
                bif.t = 4'b0000;
            end else begin
                bif.t = 4'b0100;
                n++;
            end
            qe = ((n / 4) % 2) != 0;
            expect_v(pk({1'b0, qe, 2'b0}, 4'h0, 4'h0),
                     $sformatf("free c%0d", c));
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e.v)
                $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
            else
                passes++;
        end
        idle();
    endtask

    task automatic test_burst();
        exp_t e;
        int st[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
        int bu[8] = '{3, 3, 5, 5, 5, 5, 0, 0};
        int eq[8] = '{0, 1, 0, 1, 1, 1, 1, 1};
        int eb[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        int ed[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
        idle();
        set_ch(3, 2'b11, 16'd0, 16'd3);
        clear_all();
        for (int c = 0; c < 8; c++) begin
            bif.start = (st[c] != 0) ? 4'b1000 : 4'b0000;
            bif.burst[48 +: 16] = 16'(bu[c]);
            expect_v(pk({eq[c] != 0, 3'b0},
                        {eb[c] != 0, 3'b0},
                        {ed[c] != 0, 3'b0}),
                     $sformatf("burst c%0d", c));
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e.v)
                $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
            else
                passes++;
        end
        idle();
    endtask

    // kind 0: clear, 1: mode change, 2: async reset
    task automatic test_abort(int kind);
        exp_t e;
        logic qe;
        idle();
        clear_all();
        bif.t = 4'b1000;
        expect_v(pk(4'b1000, 4'h0, 4'h0), "abort preset q");
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e.v)
            $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
        else
            passes++;
        bif.t = 4'b0000;
        set_ch(3, 2'b11, 16'd4, 16'd10);
        expect_v(pk(4'b1000, 4'h0, 4'h0), "abort enter burst");
        tick();
        e = sb.pop_front();
        checks++;
        if (obs !== e.v)
            $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
        else
            passes++;
        qe = 1'b1;
        for (int k = 0; k < 12; k++) begin
            bif.start = (k == 0) ? 4'b1000 : 4'b0000;
            if (k > 0 && k % 5 == 0) qe = ~qe;
            expect_v(pk({qe, 3'b0}, 4'b1000, 4'h0),
                     $sformatf("abort%0d run k%0d", kind, k));
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e.v)
                $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
            else
                passes++;
        end
        if (kind == 0) begin
            bif.clear = 4'b1000;
            qe = 1'b0;
            expect_v(pk(4'h0, 4'h0, 4'h0), "abort clear");
            tick();
            bif.clear = 4'b0000;
        end else if (kind == 1) begin
            set_ch(3, 2'b00, 16'd4, 16'd10);
            expect_v(pk(4'b1000, 4'h0, 4'h0), "abort mode change");
            tick();
        end else begin
            reset = 1'b0;
            qe = 1'b0;
            #1;
            expect_v(pk(4'h0, 4'h0, 4'h0), "abort async reset");
        end
        e = sb.pop_front();
        checks++;
        if (obs !== e.v)
            $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
        else
            passes++;
        if (kind == 2) begin
            idle();
            tick();
            reset = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            expect_v(pk({qe, 3'b0}, 4'h0, 4'h0),
                     $sformatf("abort%0d after k%0d", kind, k));
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e.v)
                $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
            else
                passes++;
        end
        idle();
    endtask

    task automatic test_independent();
        exp_t e;
        logic [3:0] qv;
        logic [3:0] bv;
        logic [3:0] dv;
        int         c3;
        idle();
        set_ch(0, 2'b00, 16'd0, 16'd0);
        set_ch(1, 2'b01, 16'd2, 16'd0);
        set_ch(2, 2'b10, 16'd3, 16'd0);
        set_ch(3, 2'b11, 16'd0, 16'd3);
        clear_all();
        for (int n = 1; n <= 16; n++) begin
            bif.t     = 4'b1111;
            bif.start = (n == 1) ? 4'b1000 : 4'b0000;
            c3 = (n <= 1) ? 0 : ((n - 1 > 3) ? 3 : n - 1);
            qv[0] = (n % 2) != 0;
            qv[1] = ((n / 3) % 2) != 0;
            qv[2] = ((n / 4) % 2) != 0;
            qv[3] = (c3 % 2) != 0;
            bv = {n <= 3, 3'b0};
            dv = {n == 4, 3'b0};
            expect_v(pk(qv, bv, dv), $sformatf("indep n%0d", n));
            tick();
            e = sb.pop_front();
            checks++;
            if (obs !== e.v)
                $display("FAIL %s: got %h want %h", e.nm, obs, e.v);
            else
                passes++;
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        test_reset();
        test_direct();
        test_divided();
        test_free();
        test_burst();
        test_abort(0);
        test_abort(1);
        test_abort(2);
        test_independent();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
